dice_roller: RTL and testbench
==============================

// Module: dice_roller
// PURPOSE
//   Upstream of the game FSM. Conditions the raw roll push-button and generates the two die values.
//   Two counters run freely; releasing the button captures them as the result of the roll.
//   Presents die1/die2/sum plus a one-cycle roll_valid strobe for the game FSM to consume.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  consecutive stable cycles required before the debounced level changes (>=2)
//   DB_CNT_W         16     debounce counter width; must satisfy 2**DB_CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clock       in   1  system clock; the only clock
//   reset       in   1  synchronous, active-high reset
//   roll_btn    in   1  raw, asynchronous, bouncy roll button (1 = pressed)
//   rolling     out  1  1 while the debounced button is held (roll in progress)
//   roll_valid  out  1  one-cycle strobe; die1/die2/sum updated in the same cycle
//   die1        out  3  last captured die 1 value, 1..6 (0 = no roll since reset)
//   die2        out  3  last captured die 2 value, 1..6 (0 = no roll since reset)
//   sum         out  4  die1+die2, 2..12 (0 = no roll since reset)
// BEHAVIOUR
//   Reset: rolling=0, roll_valid=0, die1=die2=sum=0. Internal counters cnt1=cnt2=1. Synchronizer and
//     debounced level cleared to 0. Debounce counter cleared to 0. State = IDLE. Reset beats every other event.
//   Input: roll_btn passes through a 2-FF synchronizer (2 cycles of latency) before the debouncer.
//   Debounce: when sync != db_level, the counter increments; when it reaches DEBOUNCE_CYCLES-1, db_level
//     takes the sync value and the counter clears. When sync == db_level, the counter clears.
//     Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
//   Counters: update every cycle regardless of state. cnt1 runs 1..6 and wraps 6->1.
//     cnt2 advances only on the cycle cnt1 wraps, also wrapping 6->1. Both at 6 -> both 1 on the next cycle.
//     Counters never hold 0 or 7.
//   FSM states IDLE, ROLLING, CAPTURE:
//     IDLE    -> ROLLING on db_level rising edge.
//     ROLLING -> CAPTURE on db_level falling edge; rolling=1 throughout ROLLING.
//     CAPTURE -> IDLE unconditionally after 1 cycle.
//   Capture: in the cycle the FSM enters CAPTURE, the values cnt1/cnt2 held in the falling-edge cycle are
//     registered into die1/die2 and sum=cnt1+cnt2 (4-bit, no overflow possible). roll_valid=1 that cycle only.
//   Outputs are registered. die1/die2/sum hold until the next capture.
//   Reset asserted mid-ROLLING: abort, no roll_valid, outputs return to 0.
//   A press that starts during CAPTURE is still seen, because db_level is sampled again in IDLE.
//   Presses never queue: only db_level edges matter.
// STRUCTURE
//   Package dice_pkg:
//     - state typedef {IDLE, ROLLING, CAPTURE}
//     - DIE_MIN=1, DIE_MAX=6, DIE_W=3, SUM_W=4
//   Sub-module button_debouncer (#DEBOUNCE_CYCLES, DB_CNT_W): synchronizer + debounce counter.
//     Outputs db_level, rise and fall pulses.
//   Die counters, FSM and capture registers live in dice_roller.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset, roll_btn=0 for 100 cycles -> roll_valid never 1; die1=die2=sum=0; rolling=0.
//   2. Glitch: roll_btn=1 for 2 cycles, then 0 -> rolling stays 0, no roll_valid.
//   3. Press 20 cycles, release -> rolling=1 ~6 cycles after press.
//      Single roll_valid ~6 cycles after release; die1/die2 match reference counter model; sum=die1+die2.
//   4. Force release timing so counters read (6,6) at capture -> die1=6, die2=6, sum=12.
//      Next roll captured at the following cycle offset -> (1,1), sum=2 (double wrap).
//   5. Reset asserted during ROLLING -> next cycle rolling=0, outputs 0, no roll_valid; FSM back to IDLE.
//   6. Bouncy press (1/0 toggling every cycle for 10 cycles, then steady 1 for 30, then steady 0)
//      -> exactly one roll_valid; sum in 2..12.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam int unsigned DIE_MIN = 1;
  localparam int unsigned DIE_MAX = 6;
  localparam int unsigned DIE_W   = 3;
  localparam int unsigned SUM_W   = 4;

  // Next face of a die counter, wrapping DIE_MAX back to DIE_MIN.
  function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] v);
    if (v == DIE_W'(DIE_MAX)) begin
      return DIE_W'(DIE_MIN);
    end
    return v + DIE_W'(1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer; emits level and edge pulses.
module button_debouncer
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_CNT_W        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic db_level,
  output logic rise,
  output logic fall
);

  localparam logic [DB_CNT_W-1:0] CntMax = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                db_q, db_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Next state: count consecutive disagreeing cycles, flip the level on the last one.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d   = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Pulses are aligned with the cycle in which the new level first appears.
  assign db_level = db_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/dice_roller.sv
// Free-running die counters captured on debounced button release.
module dice_roller
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll_btn,
  output logic             rolling,
  output logic             roll_valid,
  output logic [DIE_W-1:0] die1,
  output logic [DIE_W-1:0] die2,
  output logic [SUM_W-1:0] sum
);

  logic db_level;
  logic db_rise;
  logic db_fall;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .btn     (roll_btn),
    .db_level(db_level),
    .rise    (db_rise),
    .fall    (db_fall)
  );

  state_e           state_q, state_d;
  logic [DIE_W-1:0] cnt1_q, cnt1_d;
  logic [DIE_W-1:0] cnt2_q, cnt2_d;
  logic             rolling_q, rolling_d;
  logic             valid_q, valid_d;
  logic [DIE_W-1:0] die1_q, die1_d;
  logic [DIE_W-1:0] die2_q, die2_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  // Next state: counters run every cycle; FSM captures them on the debounced release.
  always_comb begin
    cnt1_d  = die_next(cnt1_q);
    cnt2_d  = (cnt1_q == DIE_W'(DIE_MAX)) ? die_next(cnt2_q) : cnt2_q;
    state_d = state_q;
    valid_d = 1'b0;
    die1_d  = die1_q;
    die2_d  = die2_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (db_rise) state_d = ROLLING;
      end
      ROLLING: begin
        if (db_fall) begin
          state_d = CAPTURE;
          die1_d  = cnt1_q;
          die2_d  = cnt2_q;
          sum_d   = SUM_W'(cnt1_q) + SUM_W'(cnt2_q);
          valid_d = 1'b1;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rolling_d = (state_d == ROLLING);
  end

  // State and registered outputs; reset aborts any roll in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt1_q    <= DIE_W'(DIE_MIN);
      cnt2_q    <= DIE_W'(DIE_MIN);
      rolling_q <= 1'b0;
      valid_q   <= 1'b0;
      die1_q    <= '0;
      die2_q    <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      rolling_q <= rolling_d;
      valid_q   <= valid_d;
      die1_q    <= die1_d;
      die2_q    <= die2_d;
      sum_q     <= sum_d;
    end
  end

  assign rolling    = rolling_q;
  assign roll_valid = valid_q;
  assign die1       = die1_q;
  assign die2       = die2_q;
  assign sum        = sum_q;

endmodule

// File: tb/tb_dice_roller.sv
// Randomized bench for dice_roller with an event-level reference model.
module tb_dice_roller;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       roll_btn = 1'b0;
  logic       rolling;
  logic       roll_valid;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;

  dice_roller #(
    .DEBOUNCE_CYCLES(DB),
    .DB_CNT_W       (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .roll_btn  (roll_btn),
    .rolling   (rolling),
    .roll_valid(roll_valid),
    .die1      (die1),
    .die2      (die2),
    .sum       (sum)
  );

  always #5 clock = ~clock;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int valid_seen = 0;
  bit rolling_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model. tick = cycles since reset, so the pair of dice is a base-6 clock
  // over 36 steps; sync is the button delayed by two samples; the level flips after
  // DB consecutive disagreeing synced samples.
  int tick;
  bit hist1, hist2;
  bit m_db, m_db_prev;
  int run;
  int phase;  // 0 waiting for press, 1 held, 2 capture cycle
  int m_d1, m_d2, m_sum;
  bit m_valid, m_rolling;
  bit rose, fell;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        tick = 0; hist1 = 0; hist2 = 0; m_db = 0; m_db_prev = 0; run = 0;
        phase = 0; m_d1 = 0; m_d2 = 0; m_sum = 0; m_valid = 0;
      end else begin
        rose = m_db && !m_db_prev;
        fell = !m_db && m_db_prev;
        m_valid = 0;
        if (phase == 0) begin
          if (rose) phase = 1;
        end else if (phase == 1) begin
          if (fell) begin
            phase   = 2;
            m_d1    = tick % 6 + 1;
            m_d2    = tick / 6 + 1;
            m_sum   = m_d1 + m_d2;
            m_valid = 1;
          end
        end else begin
          phase = 0;
        end
        m_db_prev = m_db;
        if (hist2 != m_db) begin
          run++;
          if (run == DB) begin
            m_db = hist2;
            run  = 0;
          end
        end else begin
          run = 0;
        end
        hist2 = hist1;
        hist1 = roll_btn;
        tick  = (tick + 1) % 36;
      end
      m_rolling = (phase == 1);
      #1;
      check("rolling", rolling, m_rolling);
      check("roll_valid", roll_valid, m_valid);
      check("die1", die1, m_d1);
      check("die2", die2, m_d2);
      check("sum", sum, m_sum);
      if (roll_valid) valid_seen++;
      if (rolling) rolling_seen = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rolling(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rolling && n < 60);
    if (!rolling) check("rolling_timeout", rolling, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!roll_valid && n < 60);
    if (!roll_valid) check("valid_timeout", roll_valid, 1);
  endtask

  // Wait until releasing now puts the capture on counter step target.
  task automatic release_at(input int target);
    int guard;
    guard = 0;
    while (((tick + 6) % 36) != target && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    roll_btn = 1'b0;
  endtask

  int n, vs;

  initial begin
    cyc(3);
    reset = 1'b0;

    // Idle after reset.
    cyc(100);
    check("t1_valid_count", valid_seen, 0);
    check("t1_rolling_seen", rolling_seen, 0);
    check("t1_die1", die1, 0);
    check("t1_sum", sum, 0);

    // Short glitch is ignored.
    roll_btn = 1'b1;
    cyc(2);
    roll_btn = 1'b0;
    cyc(20);
    check("t2_rolling_seen", rolling_seen, 0);
    check("t2_valid_count", valid_seen, 0);

    // Clean 20-cycle press.
    roll_btn = 1'b1;
    wait_rolling(n);
    check("t3_press_latency", n, 7);
    cyc(20 - n);
    roll_btn = 1'b0;
    wait_valid(n);
    check("t3_release_latency", n, 7);
    check("t3_sum_consistent", sum, die1 + die2);
    cyc(10);
    check("t3_valid_count", valid_seen, 1);

    // Randomized rolls, some with leading bounce, some too short to register.
    repeat (14) begin
      repeat ($urandom_range(0, 4)) begin
        roll_btn = ~roll_btn;
        cyc(1);
      end
      roll_btn = 1'b1;
      cyc($urandom_range(2, 40));
      roll_btn = 1'b0;
      cyc($urandom_range(6, 30));
    end

    // Capture on (6,6), then on the following step (1,1).
    roll_btn = 1'b1;
    cyc(12);
    release_at(35);
    wait_valid(n);
    check("t4_die1_max", die1, 6);
    check("t4_die2_max", die2, 6);
    check("t4_sum_max", sum, 12);
    cyc(10);
    roll_btn = 1'b1;
    cyc(12);
    release_at(0);
    wait_valid(n);
    check("t4_die1_wrap", die1, 1);
    check("t4_die2_wrap", die2, 1);
    check("t4_sum_wrap", sum, 2);
    cyc(10);

    // Reset while rolling.
    roll_btn = 1'b1;
    wait_rolling(n);
    cyc(3);
    vs = valid_seen;
    reset = 1'b1;
    roll_btn = 1'b0;
    cyc(1);
    check("t5_rolling", rolling, 0);
    check("t5_die1", die1, 0);
    check("t5_sum", sum, 0);
    check("t5_valid", roll_valid, 0);
    reset = 1'b0;
    cyc(20);
    check("t5_no_valid", valid_seen, vs);

    // Bouncy press yields exactly one roll.
    vs = valid_seen;
    for (int i = 0; i < 10; i++) begin
      roll_btn = i[0] ? 1'b0 : 1'b1;
      cyc(1);
    end
    roll_btn = 1'b1;
    cyc(30);
    roll_btn = 1'b0;
    cyc(30);
    check("t6_one_valid", valid_seen - vs, 1);
    check("t6_sum_range", (sum >= 2 && sum <= 12) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
